// File: rtl/ga_pkg.sv
// Shared types and constants for the genetic algorithm engine.
// Holds the FSM state set, LFSR constants and the fitness rule.
package ga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    BREED,
    SWAP,
    DONE
  } ga_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fitness = value of the chromosome plus its number of set bits
  function automatic logic [31:0] ga_fitness(
    input logic [31:0] c
  );
    logic [31:0] pc;
    pc = '0;
    for (int i = 0; i < 32; i++) begin
      pc = pc + 32'(c[i]);
    end
    return c + pc;
  endfunction

endpackage

// File: rtl/ga_lfsr.sv
// 16-bit maximal-length Galois LFSR.
// Advances when enabled, reloads the seed on reset.
module ga_lfsr
  import ga_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic [15:0] w_step;

  // One Galois shift: feed the dropped bit back into the taps
  always_comb begin
    w_step = {1'b0, r_lfsr[15:1]};
    if (r_lfsr[0]) begin
      w_step = w_step ^ LFSR_TAPS;
    end
  end

  // Shift register with synchronous reseed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= w_step;
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/genetic_algorithm.sv
// Genetic algorithm engine: evaluate, breed with elitism,
// tournament selection, single-point crossover and mutation.
module genetic_algorithm
  import ga_pkg::*;
#(
  parameter int         CHROMOSOME_WIDTH = 8,
  parameter int         POPULATION_SIZE  = 16,
  parameter int         MAX_GENERATIONS  = 100,
  parameter int         FITNESS_WIDTH    = 10,
  parameter logic [7:0] MUTATION_RATE    = 8'h10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_ga,
  input  logic [CHROMOSOME_WIDTH-1:0]
               initial_population [POPULATION_SIZE],
  output logic [CHROMOSOME_WIDTH-1:0] best_chromosome,
  output logic [FITNESS_WIDTH-1:0]    best_fitness,
  output logic ga_done
);

  localparam int CW = CHROMOSOME_WIDTH;
  localparam int FW = FITNESS_WIDTH;
  localparam int P  = POPULATION_SIZE;
  localparam int IW = $clog2(P);
  localparam int GW = $clog2(MAX_GENERATIONS + 1);

  localparam logic [IW-1:0] LAST    = IW'(P - 1);
  localparam logic [GW-1:0] GEN_END = GW'(MAX_GENERATIONS);
  localparam logic [7:0]    CUT_MOD = 8'(CW - 1);
  localparam logic [7:0]    POS_MOD = 8'(CW);

  typedef logic [CW-1:0] chrom_t;
  typedef logic [FW-1:0] fit_t;

  ga_state_e     r_state;
  ga_state_e     w_next;
  logic [IW-1:0] r_idx;
  logic [GW-1:0] r_gen;
  chrom_t        r_best;
  fit_t          r_best_fit;
  chrom_t        r_pop  [P];
  chrom_t        r_next [P];
  fit_t          r_fit  [P];

  logic [15:0]   w_rnd;
  logic [31:0]   w_mix;
  fit_t          w_f;
  logic          w_last;
  logic [IW-1:0] w_i0;
  logic [IW-1:0] w_i1;
  logic [IW-1:0] w_i2;
  logic [IW-1:0] w_i3;
  logic [IW-1:0] w_pa;
  logic [IW-1:0] w_pb;
  logic [7:0]    w_cut;
  logic [7:0]    w_mpos;
  logic [8:0]    w_diff;
  chrom_t        w_mask;
  chrom_t        w_cross;
  chrom_t        w_child;

  // Binary tournament: fitter wins, ties go to the lower index
  function automatic logic [IW-1:0] pick(
    input logic [IW-1:0] a,
    input logic [IW-1:0] b,
    input fit_t          fa,
    input fit_t          fb
  );
    if (fa > fb) return a;
    if (fb > fa) return b;
    return (a < b) ? a : b;
  endfunction

  ga_lfsr u_lfsr (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_en   (r_state != IDLE),
    .o_lfsr (w_rnd)
  );

  // Fitness of the chromosome under evaluation
  always_comb begin
    w_f    = FW'(ga_fitness(32'(r_pop[r_idx])));
    w_last = (r_idx == LAST);
  end

  // Child construction from this cycle's random word
  always_comb begin
    w_mix  = {{w_rnd[8:0], w_rnd[15:9]} ^ w_rnd, w_rnd};
    w_i0   = IW'(w_mix);
    w_i1   = IW'(w_mix >> IW);
    w_i2   = IW'(w_mix >> (2 * IW));
    w_i3   = IW'(w_mix >> (3 * IW));
    w_pa   = pick(w_i0, w_i1, r_fit[w_i0], r_fit[w_i1]);
    w_pb   = pick(w_i2, w_i3, r_fit[w_i2], r_fit[w_i3]);
    w_cut  = (w_rnd[15:8] % CUT_MOD) + 8'd1;
    w_mask = (CW'(1) << w_cut) - CW'(1);
    w_cross = (r_pop[w_pa] & w_mask)
            | (r_pop[w_pb] & ~w_mask);
    w_mpos = w_mix[31:24] % POS_MOD;
    // borrow out means the random byte is below the rate
    w_diff = {1'b0, w_rnd[7:0]} - {1'b0, MUTATION_RATE};
    w_child = w_cross;
    if (w_diff[8]) begin
      w_child = w_cross ^ (CW'(1) << w_mpos);
    end
  end

  // Next-state sequencing of the run
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start_ga) w_next = LOAD;
      LOAD:  w_next = EVAL;
      EVAL:  if (w_last) begin
               w_next = (r_gen == GEN_END) ? DONE : BREED;
             end
      BREED: if (w_last) w_next = SWAP;
      SWAP:  w_next = EVAL;
      DONE:  if (!start_ga) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Control state, counters and best-so-far tracking
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_gen      <= '0;
      r_best     <= '0;
      r_best_fit <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        LOAD: begin
          r_idx      <= '0;
          r_gen      <= '0;
          r_best     <= '0;
          r_best_fit <= '0;
        end
        EVAL: begin
          r_idx <= r_idx + 1'b1;
          if (w_f > r_best_fit) begin
            r_best     <= r_pop[r_idx];
            r_best_fit <= w_f;
          end
        end
        BREED: r_idx <= r_idx + 1'b1;
        SWAP: begin
          r_idx <= '0;
          r_gen <= r_gen + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Population, fitness and next-generation storage
  always_ff @(posedge clk) begin
    case (r_state)
      LOAD: begin
        for (int i = 0; i < P; i++) begin
          r_pop[i] <= initial_population[i];
        end
      end
      EVAL: r_fit[r_idx] <= w_f;
      BREED: begin
        r_next[r_idx] <= (r_idx == '0) ? r_best : w_child;
      end
      SWAP: begin
        for (int i = 0; i < P; i++) begin
          r_pop[i] <= r_next[i];
        end
      end
      default: ;
    endcase
  end

  assign best_chromosome = r_best;
  assign best_fitness    = r_best_fit;
  assign ga_done         = (r_state == DONE);

endmodule

// File: tb/tb_genetic_algorithm.sv
// Bench for genetic_algorithm: two instances (no mutation and
// default mutation) driven together, checked by a scoreboard.
module tb_genetic_algorithm;

  localparam int CW  = 8;
  localparam int P   = 16;
  localparam int G   = 100;
  localparam int FW  = 10;
  localparam int LAT = 1 + G * (2 * P + 1) + P + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_ga;
  logic [CW-1:0] pop [P];
  logic [CW-1:0] best_a, best_b;
  logic [FW-1:0] fit_a, fit_b;
  logic          done_a, done_b;

  always #5 clk = ~clk;

  genetic_algorithm #(
    .CHROMOSOME_WIDTH (CW),
    .POPULATION_SIZE  (P),
    .MAX_GENERATIONS  (G),
    .FITNESS_WIDTH    (FW),
    .MUTATION_RATE    (8'h00)
  ) u_dut_a (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_ga           (start_ga),
    .initial_population (pop),
    .best_chromosome    (best_a),
    .best_fitness       (fit_a),
    .ga_done            (done_a)
  );

  genetic_algorithm #(
    .CHROMOSOME_WIDTH (CW),
    .POPULATION_SIZE  (P),
    .MAX_GENERATIONS  (G),
    .FITNESS_WIDTH    (FW),
    .MUTATION_RATE    (8'h10)
  ) u_dut_b (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_ga           (start_ga),
    .initial_population (pop),
    .best_chromosome    (best_b),
    .best_fitness       (fit_b),
    .ga_done            (done_b)
  );

  typedef struct {
    int            start;
    bit            exact;
    logic [CW-1:0] chrom;
    int            minf;
    logic [CW-1:0] mask;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int fref(logic [CW-1:0] c);
    return int'(c) + $countones(c);
  endfunction

  function automatic exp_t mk(bit ex, logic [CW-1:0] c,
                              int mf, logic [CW-1:0] m);
    exp_t e;
    e.start = 0;
    e.exact = ex;
    e.chrom = c;
    e.minf  = mf;
    e.mask  = m;
    return e;
  endfunction

  function automatic int max_f();
    int m = 0;
    for (int i = 0; i < P; i++) begin
      if (fref(pop[i]) > m) m = fref(pop[i]);
    end
    return m;
  endfunction

  function automatic logic [CW-1:0] or_all();
    logic [CW-1:0] o = '0;
    for (int i = 0; i < P; i++) o = o | pop[i];
    return o;
  endfunction

  task automatic chk(string nm, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic chk_ge(string nm, int act, int lo);
    compared++;
    if (act < lo) begin
      mismatched++;
      $display("FAIL %s: got %0d, want >= %0d", nm, act, lo);
    end
  endtask

  task automatic judge(string tag, exp_t e,
                       logic [CW-1:0] bc, logic [FW-1:0] bf);
    chk({tag, " latency"}, cyc - e.start + 1, LAT);
    if (e.exact) begin
      chk({tag, " best chrom"}, int'(bc), int'(e.chrom));
      chk({tag, " best fit"}, int'(bf), e.minf);
    end else begin
      chk_ge({tag, " best fit"}, int'(bf), e.minf);
      chk({tag, " foreign bits"}, int'(bc & ~e.mask), 0);
    end
    chk({tag, " f(best)"}, int'(bf), fref(bc));
  endtask

  task automatic randomize_pop();
    for (int i = 0; i < P; i++) pop[i] = CW'($urandom);
  endtask

  task automatic launch(exp_t ea, exp_t eb, bit hold);
    @(negedge clk);
    start_ga = 1'b1;
    ea.start = cyc + 1;
    eb.start = cyc + 1;
    qa.push_back(ea);
    qb.push_back(eb);
    if (!hold) begin
      @(negedge clk);
      start_ga = 1'b0;
    end
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!done_a && n < LAT + 100) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout: ga_done 0 after %0d cycles",
               nm, n);
    end
  endtask

  // Monitor for the mutation-free instance
  logic pda = 1'b0;
  int   lfa = 0;
  always @(negedge clk) begin
    if (done_a && !pda) begin
      if (qa.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL a unexpected done: got 1, want 0");
      end else begin
        judge("a", qa.pop_front(), best_a, fit_a);
      end
    end
    pda = done_a;
    if (rst_n) begin
      lfa = int'(fit_a);
    end else if (int'(fit_a) != lfa) begin
      if (fit_a != '0) begin
        chk_ge("a monotonic", int'(fit_a), lfa);
        chk("a live f(best)", int'(fit_a), fref(best_a));
      end
      lfa = int'(fit_a);
    end
  end

  // Monitor for the mutating instance
  logic pdb = 1'b0;
  int   lfb = 0;
  always @(negedge clk) begin
    if (done_b && !pdb) begin
      if (qb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL b unexpected done: got 1, want 0");
      end else begin
        judge("b", qb.pop_front(), best_b, fit_b);
      end
    end
    pdb = done_b;
    if (rst_n) begin
      lfb = int'(fit_b);
    end else if (int'(fit_b) != lfb) begin
      if (fit_b != '0) begin
        chk_ge("b monotonic", int'(fit_b), lfb);
        chk("b live f(best)", int'(fit_b), fref(best_b));
      end
      lfb = int'(fit_b);
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, " done_a"}, int'(done_a), 0);
    chk({tag, " best_a"}, int'(best_a), 0);
    chk({tag, " fit_a"}, int'(fit_a), 0);
    chk({tag, " done_b"}, int'(done_b), 0);
    chk({tag, " best_b"}, int'(best_b), 0);
    chk({tag, " fit_b"}, int'(fit_b), 0);
  endtask

  initial begin
    int j;
    int mf;
    logic [CW-1:0] om;
    rst_n    = 1'b1;
    start_ga = 1'b0;
    for (int i = 0; i < P; i++) pop[i] = '0;
    repeat (5) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b0;

    // all-zero population
    launch(mk(1, 8'h00, 0, 8'hFF),
           mk(0, 8'h00, 0, 8'hFF), 1'b0);
    wait_done("zero pop");

    // single FF entry among zeros
    j = $urandom_range(P - 1);
    pop[j] = 8'hFF;
    launch(mk(1, 8'hFF, 263, 8'hFF),
           mk(1, 8'hFF, 263, 8'hFF), 1'b0);
    wait_done("single FF");
    repeat (5) @(negedge clk);
    chk("idle hold best_a", int'(best_a), 255);
    chk("idle hold fit_a", int'(fit_a), 263);
    chk("idle done_a", int'(done_a), 0);

    // random populations
    for (int r = 0; r < 2; r++) begin
      randomize_pop();
      mf = max_f();
      om = or_all();
      launch(mk(0, 8'h00, mf, om),
             mk(0, 8'h00, mf, 8'hFF), 1'b0);
      wait_done("random pop");
    end

    // reset in the middle of a run
    randomize_pop();
    @(negedge clk);
    start_ga = 1'b1;
    @(negedge clk);
    start_ga = 1'b0;
    repeat (498) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("mid-run reset");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("post-reset idle done_a", int'(done_a), 0);
    mf = max_f();
    om = or_all();
    launch(mk(0, 8'h00, mf, om),
           mk(0, 8'h00, mf, 8'hFF), 1'b0);
    wait_done("restart");

    // start held high through done
    randomize_pop();
    mf = max_f();
    om = or_all();
    launch(mk(0, 8'h00, mf, om),
           mk(0, 8'h00, mf, 8'hFF), 1'b1);
    wait_done("held start");
    repeat (8) begin
      @(negedge clk);
      chk("held done_a", int'(done_a), 1);
    end
    start_ga = 1'b0;
    @(negedge clk);
    chk("drop done_a", int'(done_a), 0);
    chk("drop done_b", int'(done_b), 0);

    // re-raise starts a new run
    randomize_pop();
    mf = max_f();
    om = or_all();
    launch(mk(0, 8'h00, mf, om),
           mk(0, 8'h00, mf, 8'hFF), 1'b0);
    wait_done("re-raise");

    repeat (3) @(negedge clk);
    chk("queue a drained", qa.size(), 0);
    chk("queue b drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
